alu_arbiter: RTL
================

# alu_arbiter

Shares the single combinational ALU between two requesters, the execute-stage issue port (requester 0) and the address/branch-compare port (requester 1). It uses valid/ready handshakes and round-robin arbitration. The block latches one request and drives the ALU from registers for one cycle. It then captures the result and flags, and holds the response until the winning requester accepts it.

## Interface
- `RR_ENABLE`, default 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins.
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid`, `req1_valid` in 1: request pending.
- `req0_ready`, `req1_ready` out 1: request accepted this cycle when valid and ready are both high.
- `req0_op1`, `req0_op2`, `req1_op1`, `req1_op2` in 32: ALU operands.
- `req0_field`, `req1_field` in 4: ALU operation code, `{funct7[5], funct3}`.
- `rsp0_valid`, `rsp1_valid` out 1: response available for that requester.
- `rsp0_ready`, `rsp1_ready` in 1: requester consumes the response.
- `rsp_result` out 32: captured ALU result, shared by both response ports.
- `rsp_flags` out 4: captured `{zero, sign, overflow, carry}`.
- `rsp_err` out 1: the request used an unsupported field code.
- `alu_op1`, `alu_op2` out 32: operands driven to the ALU.
- `alu_field` out 4: operation code driven to the ALU.
- `alu_result` in 32: result returned by the ALU.
- `alu_zero`, `alu_sign`, `alu_overflow`, `alu_carry` in 1: flags returned by the ALU.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant is computed combinationally from valids and `last_grant`.
  - Only the granted requester's ready is high.
  - On handshake, latch op1, op2, field and the grant id, then go to EXEC.
  - If no valid request, stay in IDLE.
- **Arbitration**
  - With only one valid requester, it wins.
  - With both valid and `RR_ENABLE`=1, the requester not equal to `last_grant` wins.
  - With both valid and `RR_ENABLE`=0, requester 0 wins.
  - `last_grant` updates on every handshake.
  - Reset value of `last_grant` is 1, so requester 0 wins the first tie.
- **EXEC**
  - `alu_op1`, `alu_op2` and `alu_field` are driven from the latched registers.
  - At the end of the cycle, capture `alu_result` and flags into the response registers, then go to RESP.
- **Legal fields**: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0100 XOR, 0001 SLL, 0101 SRL, 1101 SRA, 0010 SLT, 0011 SLTU.
- **Illegal fields** (1001, 1010, 1011, 1100, 1110, 1111)
  - Captured result is 0, flags are 0000, `rsp_err`=1.
  - The ALU is still driven during EXEC, but its outputs are ignored.
- **Carry masking**: the captured carry is forced to 0 for every field except ADD and SUB. Zero, sign and overflow pass through unchanged.
- **RESP**
  - `rsp<g>_valid`=1 for the granted requester only.
  - `rsp_result`, `rsp_flags` and `rsp_err` are held stable.
  - When `rsp<g>_ready`=1, go to IDLE.
  - The other requester's `rsp_ready` is ignored.
- Requests arriving during EXEC or RESP see ready=0 and must hold valid and data.

## Timing
- **Reset values**
  - Outputs: state IDLE, all req/rsp ready and valid outputs 0, `busy` 0.
  - Response registers: `rsp_result` 0, `rsp_flags` 0, `rsp_err` 0.
  - ALU drive: `alu_op1`, `alu_op2`, `alu_field` all 0.
- **Reset mid-operation**: the in-flight request and response are dropped and are not re-issued.
- **Latency**
  - Handshake in cycle N; EXEC in cycle N+1; `rsp_valid` first high in cycle N+2.
  - With `rsp_ready` tied high, the response completes in N+2 and the next request is accepted in N+3.
  - Peak throughput is one operation per 3 cycles.
- **Backpressure**: RESP holds indefinitely with all response outputs stable. Both req_ready outputs stay 0 for the duration.
- `alu_*` outputs change only on a handshake edge. They remain at the last issued values while idle.
- **Simultaneous events**: a request valid in the same cycle RESP completes is not accepted until the following IDLE cycle.

## Test plan
- **Single ADD with carry**: req0 ADD, op1=0xFFFFFFFF, op2=1.
  - Required: rsp0_valid two cycles after the handshake.
  - Required: result 0x00000000, flags zero=1, carry=1, err=0.
  - Required: rsp1_valid stays 0.
- **Round-robin tie**: after reset, req0 and req1 both valid continuously (req0 SUB 5-7, req1 SLTU 3<9).
  - Required grant order: 0, 1, 0, 1.
  - Required: req0 result 0xFFFFFFFE with sign=1; req1 result 1 with carry=0.
- **Fixed priority**: repeat the tie with `RR_ENABLE`=0.
  - Required: only requester 0 is granted while it keeps req0_valid high.
  - Required: requester 1 is granted the first IDLE cycle after req0_valid drops.
- **Illegal field**: field 4'b1111 with op1=0x1234, op2=0x5678.
  - Required: result 0, flags 0000, rsp_err=1.
  - Required: the next legal request (SRA 0x80000000>>4) returns 0xF8000000 with err=0.
- **Backpressure**: hold rsp0_ready=0 for 5 cycles while req1 is valid.
  - Required: response outputs stable, req1_ready=0 throughout, busy=1.
  - Required: req1 is accepted the cycle after the IDLE return.
- **Reset in EXEC**: assert rst during EXEC.
  - Required: next cycle IDLE, all outputs at reset values, no rsp_valid ever pulses for the aborted request.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters: the execute-stage
//   issue port (requester 0) and the address/branch-compare port
//   (requester 1). One request is latched, driven to the ALU for a cycle,
//   and then the result and flags are held until the winner takes them.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req<n>_valid/ready         request handshake per requester
//   req<n>_op1/op2/field       operands and {funct7[5], funct3} op code
//   rsp<n>_valid/ready         response handshake per requester
//   rsp_result/flags/err       shared captured response; flags = {z, s, v, c}
//   alu_op1/op2/field          registered ALU drive
//   alu_result, alu_*          ALU result and flags
//   busy                       high whenever the FSM is not IDLE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate, accept one request, latch it into the ALU drive
// EXEC  | ALU evaluates latched operands; result captured at edge
// RESP  | response held for the winner until its rsp_ready
module alu_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [3:0]  req0_field,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  logic [3:0]  req1_field,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_field,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_sign,
  input  logic        alu_overflow,
  input  logic        alu_carry,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] FLD_ADD = 4'b0000;
  localparam logic [3:0] FLD_SUB = 4'b1000;

  state_t state;
  logic   last_grant;
  logic   gnt_id;       // owner of the in-flight operation
  logic   grant_vld;
  logic   grant_id;

  function automatic logic field_legal(input logic [3:0] f);
    case (f)
      4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
      4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011: field_legal = 1'b1;
      default:                                     field_legal = 1'b0;
    endcase
  endfunction

  // On a tie, round-robin picks whoever did not win last time.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = RR_ENABLE ? ~last_grant : 1'b0;
    end else begin
      grant_id = ~req0_valid;
    end
  end

  assign req0_ready = (state == IDLE) && grant_vld && !grant_id;
  assign req1_ready = (state == IDLE) && grant_vld &&  grant_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      busy       <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_field  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            alu_op1    <= grant_id ? req1_op1   : req0_op1;
            alu_op2    <= grant_id ? req1_op2   : req0_op2;
            alu_field  <= grant_id ? req1_field : req0_field;
            gnt_id     <= grant_id;
            last_grant <= grant_id;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // Illegal codes still drive the ALU, but its outputs are discarded.
          if (!field_legal(alu_field)) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_zero, alu_sign, alu_overflow,
                           alu_carry & ((alu_field == FLD_ADD) ||
                                        (alu_field == FLD_SUB))};
            rsp_err    <= 1'b0;
          end
          rsp0_valid <= ~gnt_id;
          rsp1_valid <=  gnt_id;
          state      <= RESP;
        end
        RESP: begin
          if (gnt_id ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
